// File: rtl/spi_mac_sequencer.sv
// spi_mac_sequencer
// SPI-slave (mode 0) command sequencer in front of a shared multiply-accumulate
// unit. SCK/CS_N/MOSI are synchronised into i_clk. Bits are counted into
// frames, a command byte is decoded, and operand bytes are collected. The block
// then issues single-cycle MAC strobes, or shifts an accumulator snapshot out on
// MISO.
//
// Commands (one frame each, several allowed per CS assertion):
//   0x01 A B : latch A, latch B, then pulse o_mac_en
//   0x02     : pulse o_mac_clr
//   0x03 x x : snapshot i_mac_acc and shift it out MSB first over two frames
//   other    : set sticky o_err and ignore the rest of this CS assertion
//
// Ports:
//   i_clk, i_rst         system clock (>= 8x SCK), synchronous active-high reset
//   i_sck, i_cs_n, i_mosi asynchronous SPI pins
//   o_miso               SPI data out
//   o_mac_a, o_mac_b     operands, held until the next latch
//   o_mac_en, o_mac_clr  single-cycle strobes to the MAC, never together
//   i_mac_acc            accumulator value from the MAC
//   o_busy               high while the FSM is not IDLE
//   o_err                sticky illegal-command flag, cleared at the next CS fall
//   o_state              FSM state (debug)
//
// Strobe contract: o_mac_en and o_mac_clr are pure one-cycle pulses with no
// back-pressure. The MAC must accept them in the cycle they are high.
module spi_mac_sequencer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4,
  parameter int ACC_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sck,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic [DATA_W-1:0] o_mac_a,
  output logic [DATA_W-1:0] o_mac_b,
  output logic              o_mac_en,
  output logic              o_mac_clr,
  input  logic [ACC_W-1:0]  i_mac_acc,
  output logic              o_busy,
  output logic              o_err,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    OPA   = 3'd2,
    OPB   = 3'd3,
    RD_HI = 3'd4,
    RD_LO = 3'd5,
    SKIP  = 3'd6
  } state_t;

  state_t state;

  // Sync flops reset to 0. If CS_N is already low when reset is released,
  // no false cs_fall is produced, and the sequencer waits for a fresh
  // assertion.
  logic [2:0] sck_s;
  logic [2:0] cs_s;
  logic [1:0] mosi_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sck_s  <= '0;
      cs_s   <= '0;
      mosi_s <= '0;
    end else begin
      sck_s  <= {sck_s[1:0], i_sck};
      cs_s   <= {cs_s[1:0], i_cs_n};
      mosi_s <= {mosi_s[0], i_mosi};
    end
  end

  logic sck_rise, sck_fall, cs_fall, cs_active, mosi_bit;
  assign sck_rise  = sck_s[1] & ~sck_s[2];
  assign sck_fall  = ~sck_s[1] & sck_s[2];
  assign cs_fall   = ~cs_s[1] & cs_s[2];
  assign cs_active = ~cs_s[1];
  assign mosi_bit  = mosi_s[1];

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt <= '0;
      rx      <= '0;
    end else if (!cs_active) begin
      bit_cnt <= '0;
    end else if (sck_rise) begin
      rx      <= {rx[DATA_W-2:0], mosi_bit};
      bit_cnt <= (bit_cnt == CNT_W'(DATA_W - 1)) ? '0 : bit_cnt + 1'b1;
    end
  end

  // The frame completes on the rising edge of its last bit. The frame value
  // therefore includes the bit being sampled in this cycle.
  logic              frame_done;
  logic [DATA_W-1:0] frame;
  assign frame_done = cs_active & sck_rise & (bit_cnt == CNT_W'(DATA_W - 1));
  assign frame      = {rx[DATA_W-2:0], mosi_bit};

  logic [ACC_W-1:0] tx;
  logic             hold;
  logic             en_pend;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      tx        <= '0;
      hold      <= 1'b0;
      en_pend   <= 1'b0;
      o_mac_a   <= '0;
      o_mac_b   <= '0;
      o_mac_en  <= 1'b0;
      o_mac_clr <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      // o_mac_b updates one cycle before o_mac_en, so the MAC sees stable operands.
      o_mac_en  <= en_pend;
      en_pend   <= 1'b0;
      o_mac_clr <= 1'b0;
      if (!cs_active) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            state <= CMD;
            o_err <= 1'b0;
          end
          CMD: if (frame_done) begin
            case (frame)
              DATA_W'(1): state <= OPA;
              DATA_W'(2): o_mac_clr <= 1'b1;
              DATA_W'(3): begin
                tx    <= i_mac_acc;
                hold  <= 1'b1;
                state <= RD_HI;
              end
              default: begin
                o_err <= 1'b1;
                state <= SKIP;
              end
            endcase
          end
          OPA: if (frame_done) begin
            o_mac_a <= frame;
            state   <= OPB;
          end
          OPB: if (frame_done) begin
            o_mac_b <= frame;
            en_pend <= 1'b1;
            state   <= CMD;
          end
          RD_HI, RD_LO: begin
            if (frame_done) state <= (state == RD_HI) ? RD_LO : CMD;
            // The first falling edge after the read command belongs to the
            // command frame. It must not shift away the accumulator MSB.
            if (sck_fall) begin
              if (hold) hold <= 1'b0;
              else      tx   <= {tx[ACC_W-2:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_miso  = ((state == RD_HI) || (state == RD_LO)) ? tx[ACC_W-1] : 1'b0;
  assign o_busy  = (state != IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_spi_mac_sequencer.sv
// Testbench for spi_mac_sequencer: directed test-plan transactions, then
// randomized command streams. A byte-level reference model predicts MAC
// strobes and readback bytes.
module tb_spi_mac_sequencer;

  localparam int HALF = 8;  // SCK half period in clk cycles
  localparam int W    = 19; // {kind[1:0], b_changes, a[7:0], b[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic [15:0] acc = '0;
  logic miso, mac_en, mac_clr, busy, err;
  logic [7:0] mac_a, mac_b;
  logic [2:0] state;

  always #5 clk = ~clk;

  spi_mac_sequencer #(.DATA_W(8), .CNT_W(4), .ACC_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_cs_n(cs_n), .i_mosi(mosi),
    .o_miso(miso), .o_mac_a(mac_a), .o_mac_b(mac_b), .o_mac_en(mac_en),
    .o_mac_clr(mac_clr), .i_mac_acc(acc), .o_busy(busy), .o_err(err),
    .o_state(state)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   rd_exp_q[$];
  logic [7:0]   txq[$];
  int           m_mode; // 0 cmd, 1 opA, 2 opB, 3 read hi, 4 read lo, 5 skip
  logic [7:0]   m_a = '0;
  logic [7:0]   m_b = '0;
  logic [15:0]  m_snap;
  bit           m_err;

  task automatic model_byte(input logic [7:0] b, output bit is_read);
    bit chg;
    is_read = 1'b0;
    case (m_mode)
      0: begin
        if (b == 8'h01) m_mode = 1;
        else if (b == 8'h02) exp_q.push_back({2'b10, 1'b0, m_a, m_b});
        else if (b == 8'h03) begin m_snap = acc; m_mode = 3; end
        else begin m_err = 1'b1; m_mode = 5; end
      end
      1: begin m_a = b; m_mode = 2; end
      2: begin
        chg = (b != m_b);
        m_b = b;
        exp_q.push_back({2'b01, chg, m_a, m_b});
        m_mode = 0;
      end
      3: begin is_read = 1'b1; rd_exp_q.push_back(m_snap[15:8]); m_mode = 4; end
      4: begin is_read = 1'b1; rd_exp_q.push_back(m_snap[7:0]);  m_mode = 0; end
      default: ;
    endcase
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         cyc = 0;
  int         chg_cyc = -100;
  logic [7:0] prev_b = '0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc++;
    if (rst) begin
      prev_b = mac_b;
    end else begin
      if (mac_b !== prev_b) chg_cyc = cyc;
      prev_b = mac_b;
      if (mac_en || mac_clr) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL strobe_unexpected: en=%0b clr=%0b, expected no strobe", mac_en, mac_clr);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", {30'b0, mac_clr, mac_en}, {30'b0, e[18:17]});
          check("strobe_mac_a", mac_a, e[15:8]);
          check("strobe_mac_b", mac_b, e[7:0]);
          if (e[16]) check("en_after_b_gap", cyc - chg_cyc, 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic xfer_byte(input logic [7:0] b, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      tick(HALF);
      rx = {rx[6:0], miso};
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic run_txn(input int partial);
    bit rd;
    logic [7:0] rx;
    m_mode = 0;
    m_err  = 1'b0;
    cs_n = 1'b0;
    tick(8);
    check("busy_after_cs_fall", busy, 1);
    check("err_cleared_on_cs", err, 0);
    foreach (txq[i]) begin
      model_byte(txq[i], rd);
      xfer_byte(txq[i], 8, rx);
      if (rd) check("miso_byte", rx, rd_exp_q.pop_front());
      // The snapshot is taken; later accumulator changes must not leak out.
      if (m_mode == 3) acc = 16'($urandom);
    end
    if (partial > 0) xfer_byte(8'($urandom), partial, rx);
    tick(4);
    cs_n = 1'b1;
    tick(8);
    check("busy_after_cs_rise", busy, 0);
    check("state_idle", state, 0);
    check("err_sticky", err, m_err);
    check("held_mac_a", mac_a, m_a);
    check("held_mac_b", mac_b, m_b);
    check("strobes_drained", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rx;
    bit rd;
    int r, n;
    tick(3);
    check("rst_mac_a", mac_a, 0);
    check("rst_mac_b", mac_b, 0);
    check("rst_strobes", {mac_en, mac_clr}, 0);
    check("rst_miso", miso, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_state", state, 0);
    rst = 1'b0;
    tick(4);

    // MAC op
    txq = '{8'h01, 8'h03, 8'h05};
    run_txn(0);
    // Streamed ops
    txq = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h10, 8'h10};
    run_txn(0);
    // Clear then read
    acc = 16'hBEEF;
    txq = '{8'h02, 8'h03, 8'h00, 8'h00};
    run_txn(0);
    // Illegal command
    txq = '{8'h7A, 8'h01, 8'h01, 8'h01};
    run_txn(0);
    // Abort mid-operand, then a normal transaction
    txq = '{8'h01, 8'h22};
    run_txn(4);
    txq = '{8'h01, 8'h01, 8'h02};
    run_txn(0);

    // Reset during RD_HI
    acc = 16'hFFFF;
    m_mode = 0;
    cs_n = 1'b0;
    tick(8);
    model_byte(8'h03, rd);
    xfer_byte(8'h03, 8, rx);
    xfer_byte(8'h00, 3, rx);
    check("miso_before_reset", miso, 1);
    check("busy_before_reset", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_miso", miso, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", state, 0);
    check("midrst_operands", {mac_a, mac_b}, 0);
    check("midrst_strobes", {mac_en, mac_clr}, 0);
    rst = 1'b0;
    rd_exp_q.delete();
    m_a = '0;
    m_b = '0;
    cs_n = 1'b1;
    tick(8);
    check("postrst_busy", busy, 0);

    // Randomized command streams
    for (int t = 0; t < 25; t++) begin
      txq.delete();
      acc = 16'($urandom);
      n = $urandom_range(1, 4);
      for (int c = 0; c < n; c++) begin
        r = $urandom_range(0, 9);
        if (r <= 4) begin
          txq.push_back(8'h01);
          txq.push_back(8'($urandom));
          txq.push_back(8'($urandom));
        end else if (r <= 6) begin
          txq.push_back(8'h02);
        end else if (r <= 8) begin
          txq.push_back(8'h03);
          txq.push_back(8'($urandom));
          txq.push_back(8'($urandom));
        end else begin
          txq.push_back(8'($urandom_range(4, 255)));
          for (int j = 0; j < int'($urandom_range(0, 2)); j++) txq.push_back(8'($urandom));
        end
      end
      run_txn(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
    end

    tick(20);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
